// File: rtl/lab3_demux4.sv
// lab3_demux4: receive side of the 4-slot time-multiplexed link.
// Collects slot beats into a shadow register and publishes all four lanes
// at once when a complete frame has arrived; partial frames are discarded.
module lab3_demux4 #(
    parameter int unsigned DATA_W  = 1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sof,
    input  logic                  din_valid,
    input  logic [DATA_W-1:0]     din,
    output logic [4*DATA_W-1:0]   y,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [1:0]            slot,
    output logic                  busy
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t                  state, state_nx;
    logic [3*DATA_W-1:0]     shadow, shadow_nx;
    logic [4*DATA_W-1:0]     y_nx;
    logic [1:0]              slot_nx;
    logic [7:0]              idle_cnt, idle_cnt_nx;
    logic                    frame_valid_nx, frame_err_nx;

    assign busy = (state == COLLECT);

    // State and all registered outputs; reset discards any partial frame silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shadow      <= '0;
            y           <= '0;
            slot        <= '0;
            idle_cnt    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            shadow      <= shadow_nx;
            y           <= y_nx;
            slot        <= slot_nx;
            idle_cnt    <= idle_cnt_nx;
            frame_valid <= frame_valid_nx;
            frame_err   <= frame_err_nx;
        end
    end

    // Next-state, lane steering, idle timeout and event pulses.
    always_comb begin
        state_nx       = state;
        shadow_nx      = shadow;
        y_nx           = y;
        slot_nx        = slot;
        idle_cnt_nx    = idle_cnt;
        frame_valid_nx = 1'b0;
        frame_err_nx   = 1'b0;

        case (state)
            IDLE: begin
                idle_cnt_nx = '0;
                // Non-sof beats while idle are dropped without error.
                if (din_valid && sof) begin
                    shadow_nx[0 +: DATA_W] = din;
                    slot_nx                = 2'd1;
                    state_nx               = COLLECT;
                end
            end

            COLLECT: begin
                if (din_valid) begin
                    idle_cnt_nx = '0;
                    if (sof) begin
                        // Early restart: drop the old frame, keep this beat as slot 0.
                        frame_err_nx           = 1'b1;
                        shadow_nx[0 +: DATA_W] = din;
                        slot_nx                = 2'd1;
                    end else begin
                        case (slot)
                            2'd3: begin
                                y_nx           = {din, shadow};
                                frame_valid_nx = 1'b1;
                                slot_nx        = 2'd0;
                                state_nx       = IDLE;
                            end
                            2'd2: begin
                                shadow_nx[2*DATA_W +: DATA_W] = din;
                                slot_nx                       = 2'd3;
                            end
                            2'd1: begin
                                shadow_nx[DATA_W +: DATA_W] = din;
                                slot_nx                     = 2'd2;
                            end
                            default: begin
                                shadow_nx[0 +: DATA_W] = din;
                                slot_nx                = 2'd1;
                            end
                        endcase
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    frame_err_nx = 1'b1;
                    slot_nx      = 2'd0;
                    idle_cnt_nx  = '0;
                    state_nx     = IDLE;
                end else begin
                    idle_cnt_nx = idle_cnt + 8'd1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lab3_demux4.sv
// tb_lab3_demux4: scoreboard bench for the 4-slot link receiver.
module tb_lab3_demux4;

    logic       clk;
    logic       reset;
    logic       sof;
    logic       din_valid;
    logic [0:0] din;
    logic [3:0] y;
    logic       frame_valid;
    logic       frame_err;
    logic [1:0] slot;
    logic       busy;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned err_seen;
    int unsigned exp_err;
    int unsigned fv_seen;
    int unsigned exp_fv;
    int unsigned cyc_n;
    int unsigned last_fv_cyc;
    int unsigned prev_fv_cyc;
    logic [3:0]  exp_q[$];

    lab3_demux4 #(
        .DATA_W (1),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sof        (sof),
        .din_valid  (din_valid),
        .din        (din),
        .y          (y),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .slot       (slot),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One link cycle: drive inputs, then return 1 time unit after the sampling edge.
    task automatic cyc(input logic v, input logic s, input logic d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] bits, input int unsigned gap);
        for (int unsigned k = 0; k < 4; k++) begin
            if (k == 3) begin
                exp_q.push_back(bits);
                exp_fv++;
            end
            cyc(1'b1, k == 0, bits[k]);
            if (k < 3) repeat (gap) cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Output monitor: pops the scoreboard on every frame_valid pulse.
    always @(negedge clk) begin
        cyc_n++;
        if (!reset) begin
            if (frame_valid || frame_err)
                check("fv_fe_exclusive", {31'b0, frame_valid & frame_err}, 32'd0);
            if (frame_valid) begin
                fv_seen++;
                prev_fv_cyc = last_fv_cyc;
                last_fv_cyc = cyc_n;
                if (exp_q.size() == 0)
                    check("fv_expected", 32'd0, 32'd1);
                else
                    check("frame_y", {28'b0, y}, {28'b0, exp_q.pop_front()});
            end
            if (frame_err) err_seen++;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; err_seen = 0; exp_err = 0;
        fv_seen = 0; exp_fv = 0; cyc_n = 0; last_fv_cyc = 0; prev_fv_cyc = 0;
        reset = 1'b0; sof = 1'b0; din_valid = 1'b0; din = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_y",    {28'b0, y}, 32'd0);
        check("rst_fv",   {31'b0, frame_valid}, 32'd0);
        check("rst_fe",   {31'b0, frame_err}, 32'd0);
        check("rst_slot", {30'b0, slot}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        #20 reset = 1'b0;
        @(posedge clk); #1;

        // Basic frame 1,0,1,1 with slot sequence 1,2,3,0.
        cyc(1'b1, 1'b1, 1'b1);
        check("basic_slot1", {30'b0, slot}, 32'd1);
        check("basic_busy",  {31'b0, busy}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        check("basic_slot2", {30'b0, slot}, 32'd2);
        cyc(1'b1, 1'b0, 1'b1);
        check("basic_slot3", {30'b0, slot}, 32'd3);
        check("basic_no_fv_early", {31'b0, frame_valid}, 32'd0);
        exp_q.push_back(4'b1101); exp_fv++;
        cyc(1'b1, 1'b0, 1'b1);
        check("basic_fv",    {31'b0, frame_valid}, 32'd1);
        check("basic_y",     {28'b0, y}, 32'hD);
        check("basic_slot0", {30'b0, slot}, 32'd0);
        check("basic_idle",  {31'b0, busy}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        check("basic_fv_1cyc", {31'b0, frame_valid}, 32'd0);

        // Gapped frame, 3 idle cycles between beats.
        send_frame(4'b1101, 3);
        check("gap_y", {28'b0, y}, 32'hD);
        cyc(1'b0, 1'b0, 1'b0);
        check("gap_no_err", err_seen, exp_err);

        // Early restart: sof+0, 1, then sof+1, 0, 0, 1.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        exp_err++;
        cyc(1'b1, 1'b1, 1'b1);
        check("early_fe",   {31'b0, frame_err}, 32'd1);
        check("early_y",    {28'b0, y}, 32'hD);
        check("early_slot", {30'b0, slot}, 32'd1);
        check("early_busy", {31'b0, busy}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        check("early_fe_1cyc", {31'b0, frame_err}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        exp_q.push_back(4'b1001); exp_fv++;
        cyc(1'b1, 1'b0, 1'b1);
        check("early_final_y", {28'b0, y}, 32'h9);
        cyc(1'b0, 1'b0, 1'b0);

        // Timeout: sof+1 followed by 16 idle cycles.
        cyc(1'b1, 1'b1, 1'b1);
        repeat (15) cyc(1'b0, 1'b0, 1'b0);
        check("to_not_yet_fe",   {31'b0, frame_err}, 32'd0);
        check("to_not_yet_busy", {31'b0, busy}, 32'd1);
        exp_err++;
        cyc(1'b0, 1'b0, 1'b0);
        check("to_fe",   {31'b0, frame_err}, 32'd1);
        check("to_busy", {31'b0, busy}, 32'd0);
        check("to_slot", {30'b0, slot}, 32'd0);
        check("to_y",    {28'b0, y}, 32'h9);
        cyc(1'b1, 1'b0, 1'b1);
        check("to_drop_busy", {31'b0, busy}, 32'd0);
        check("to_drop_slot", {30'b0, slot}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        // Asynchronous reset after two beats.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        din_valid = 1'b0; sof = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mrst_y",    {28'b0, y}, 32'd0);
        check("mrst_slot", {30'b0, slot}, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_fe",   {31'b0, frame_err}, 32'd0);
        #13 reset = 1'b0;
        @(posedge clk); #1;
        send_frame(4'b0011, 0);
        check("mrst_new_y", {28'b0, y}, 32'h3);

        // Back-to-back frames.
        send_frame(4'b0110, 0);
        check("b2b_y0", {28'b0, y}, 32'h6);
        send_frame(4'b1010, 0);
        check("b2b_y1", {28'b0, y}, 32'hA);
        cyc(1'b0, 1'b0, 1'b0);
        check("b2b_spacing", last_fv_cyc - prev_fv_cyc, 32'd4);

        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        check("err_count",   err_seen, exp_err);
        check("fv_count",    fv_seen, exp_fv);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
